// File: rtl/hart_mem_arbiter.sv
// Merges one HART's fetch and data ports onto a single memory port, one transaction at a time.
// Optional macro ARVI_ARB_RR_EN selects round-robin tie-breaking instead of fixed priority.
`ifndef XLEN
`define XLEN 32
`endif

module hart_mem_arbiter #(
  parameter int D_PRIORITY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_IC_DataReq,
  input  logic [`XLEN-1:0]  i_IM_Addr,
  output logic [`XLEN-1:0]  o_IM_Instr,
  output logic              o_IC_MemReady,
  input  logic              i_DM_MemRead,
  input  logic              i_DM_Wen,
  input  logic [`XLEN-1:0]  i_DM_Addr,
  input  logic [`XLEN-1:0]  i_DM_Wd,
  input  logic [3:0]        i_DM_byte_en,
  output logic [`XLEN-1:0]  o_DM_ReadData,
  output logic              o_DM_data_ready,
  output logic              o_MEM_req,
  output logic              o_MEM_we,
  output logic [`XLEN-1:0]  o_MEM_addr,
  output logic [`XLEN-1:0]  o_MEM_wdata,
  output logic [3:0]        o_MEM_be,
  input  logic              i_MEM_ack,
  input  logic [`XLEN-1:0]  i_MEM_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUS  = 3'd1,
    D_BUS  = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } state_e;

  localparam logic D_FIRST = (D_PRIORITY != 0);

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [`XLEN-1:0]   instr_q, instr_d;
  logic [`XLEN-1:0]   rdata_q, rdata_d;
  logic               d_pend;
  logic               tie_to_d;
  logic               in_i, in_d;

  assign d_pend = i_DM_MemRead | i_DM_Wen;

`ifdef ARVI_ARB_RR_EN
  // Pointer holds the side that wins the next tie: the one not granted last.
  logic pref_d_q, pref_d_d;
  assign tie_to_d = pref_d_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pref_d_q <= D_FIRST;
    else       pref_d_q <= pref_d_d;
  end
`else
  assign tie_to_d = D_FIRST;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      instr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
`ifdef ARVI_ARB_RR_EN
    pref_d_d = pref_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_IC_DataReq && (!d_pend || !tie_to_d)) begin
          state_d = I_BUS;
`ifdef ARVI_ARB_RR_EN
          pref_d_d = 1'b1;
`endif
        end else if (d_pend) begin
          state_d = D_BUS;
          // Write wins when both strobes are high; latched so a dropped request cannot flip it.
          we_d    = i_DM_Wen;
`ifdef ARVI_ARB_RR_EN
          pref_d_d = 1'b0;
`endif
        end
      end
      I_BUS: begin
        if (i_MEM_ack) begin
          instr_d = i_MEM_rdata;
          state_d = I_DONE;
        end
      end
      D_BUS: begin
        if (i_MEM_ack) begin
          rdata_d = i_MEM_rdata;
          state_d = D_DONE;
        end
      end
      // DONE states never sample requests, so a held stale request cannot re-issue.
      I_DONE:  state_d = IDLE;
      D_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_i = (state_q == I_BUS);
  assign in_d = (state_q == D_BUS);

  assign o_MEM_req       = in_i | in_d;
  assign o_MEM_we        = in_d & we_q;
  assign o_MEM_addr      = in_i ? i_IM_Addr : (in_d ? i_DM_Addr : '0);
  assign o_MEM_wdata     = (in_d & we_q) ? i_DM_Wd : '0;
  assign o_MEM_be        = (in_d & we_q) ? i_DM_byte_en : ((in_i | in_d) ? 4'hF : 4'h0);
  assign o_IC_MemReady   = (state_q == I_DONE);
  assign o_DM_data_ready = (state_q == D_DONE);
  assign o_IM_Instr      = instr_q;
  assign o_DM_ReadData   = rdata_q;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Bench for hart_mem_arbiter: directed cases plus randomized traffic against a transaction-level model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_hart_mem_arbiter;
  localparam int XL = `XLEN;
  localparam int DP = 1;

  logic          i_clk, i_rst;
  logic          i_IC_DataReq;
  logic [XL-1:0] i_IM_Addr, o_IM_Instr;
  logic          o_IC_MemReady;
  logic          i_DM_MemRead, i_DM_Wen;
  logic [XL-1:0] i_DM_Addr, i_DM_Wd, o_DM_ReadData;
  logic [3:0]    i_DM_byte_en;
  logic          o_DM_data_ready;
  logic          o_MEM_req, o_MEM_we;
  logic [XL-1:0] o_MEM_addr, o_MEM_wdata;
  logic [3:0]    o_MEM_be;
  logic          i_MEM_ack;
  logic [XL-1:0] i_MEM_rdata;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: tie preference, last completed read values.
  bit            pref_d;
  logic [XL-1:0] exp_instr, exp_dmrd;
  bit            dm_known;

  hart_mem_arbiter #(.D_PRIORITY(DP)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_IC_DataReq(i_IC_DataReq), .i_IM_Addr(i_IM_Addr),
    .o_IM_Instr(o_IM_Instr), .o_IC_MemReady(o_IC_MemReady),
    .i_DM_MemRead(i_DM_MemRead), .i_DM_Wen(i_DM_Wen),
    .i_DM_Addr(i_DM_Addr), .i_DM_Wd(i_DM_Wd), .i_DM_byte_en(i_DM_byte_en),
    .o_DM_ReadData(o_DM_ReadData), .o_DM_data_ready(o_DM_data_ready),
    .o_MEM_req(o_MEM_req), .o_MEM_we(o_MEM_we), .o_MEM_addr(o_MEM_addr),
    .o_MEM_wdata(o_MEM_wdata), .o_MEM_be(o_MEM_be),
    .i_MEM_ack(i_MEM_ack), .i_MEM_rdata(i_MEM_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic bit tie_goes_to_d();
`ifdef ARVI_ARB_RR_EN
    return pref_d;
`else
    return DP != 0;
`endif
  endfunction

  // Runs one granted transaction from the IDLE cycle in which its request is visible.
  task automatic serve(input bit is_d, input int delay, input logic [XL-1:0] rdata, input string tag);
    bit            wr;
    logic [XL-1:0] addr;
    logic [3:0]    be;
    wr   = is_d && i_DM_Wen;
    addr = is_d ? i_DM_Addr : i_IM_Addr;
    be   = wr ? i_DM_byte_en : 4'hF;
    pref_d = !is_d;
    step();
    for (int j = 1; j <= delay; j++) begin
      chk({tag, ".req"}, o_MEM_req, 1);
      chk({tag, ".addr"}, o_MEM_addr, addr);
      chk({tag, ".we"}, o_MEM_we, wr);
      chk({tag, ".be"}, o_MEM_be, be);
      if (wr) chk({tag, ".wdata"}, o_MEM_wdata, i_DM_Wd);
      chk({tag, ".rdy_busy"}, {o_IC_MemReady, o_DM_data_ready}, 0);
      if (j == delay) begin
        i_MEM_ack   = 1'b1;
        i_MEM_rdata = rdata;
      end
      step();
      i_MEM_ack   = 1'b0;
      i_MEM_rdata = $urandom;
    end
    if (!is_d) exp_instr = rdata;
    else if (!wr) begin
      exp_dmrd = rdata;
      dm_known = 1'b1;
    end else dm_known = 1'b0;
    chk({tag, ".ic_rdy"}, o_IC_MemReady, !is_d);
    chk({tag, ".dm_rdy"}, o_DM_data_ready, is_d);
    chk({tag, ".req_done"}, o_MEM_req, 0);
    chk({tag, ".instr"}, o_IM_Instr, exp_instr);
    if (dm_known) chk({tag, ".dmrd"}, o_DM_ReadData, exp_dmrd);
    step();
    chk({tag, ".req_idle"}, o_MEM_req, 0);
    chk({tag, ".rdy_idle"}, {o_IC_MemReady, o_DM_data_ready}, 0);
    chk({tag, ".instr_hold"}, o_IM_Instr, exp_instr);
    if (dm_known) chk({tag, ".dmrd_hold"}, o_DM_ReadData, exp_dmrd);
    if (is_d) begin
      i_DM_MemRead = 1'b0;
      i_DM_Wen     = 1'b0;
    end else i_IC_DataReq = 1'b0;
  endtask

  initial begin
    bit w;
    int mode;
    i_rst = 1'b1;
    i_IC_DataReq = 1'b0; i_IM_Addr = '0;
    i_DM_MemRead = 1'b0; i_DM_Wen = 1'b0;
    i_DM_Addr = '0; i_DM_Wd = '0; i_DM_byte_en = '0;
    i_MEM_ack = 1'b0; i_MEM_rdata = '0;
    pref_d = (DP != 0);
    exp_instr = '0; exp_dmrd = '0; dm_known = 1'b1;
    repeat (2) step();
    chk("rst.req", o_MEM_req, 0);
    chk("rst.rdy", {o_IC_MemReady, o_DM_data_ready}, 0);
    chk("rst.instr", o_IM_Instr, 0);
    chk("rst.dmrd", o_DM_ReadData, 0);
    i_rst = 1'b0;

    i_IC_DataReq = 1'b1; i_IM_Addr = 32'h0000_0100;
    serve(1'b0, 1, 32'h0000_0013, "fetch");

    i_DM_Wen = 1'b1; i_DM_Addr = 32'h2000_0004; i_DM_Wd = 32'hDEAD_BEEF; i_DM_byte_en = 4'b0011;
    serve(1'b1, 3, $urandom, "dwrite");

    for (int r = 0; r < 4; r++) begin
      i_IC_DataReq = 1'b1; i_IM_Addr = 32'h0000_0200 + r * 4;
      i_DM_MemRead = 1'b1; i_DM_Addr = 32'h8000_0040 + r * 4;
      w = tie_goes_to_d();
      serve(w, 1, $urandom, "tie_first");
      serve(!w, 1, $urandom, "tie_second");
    end

    i_DM_Wen = 1'b1; i_DM_Addr = 32'h9000_0000; i_DM_Wd = 32'h1234_5678; i_DM_byte_en = 4'hF;
    step();
    chk("rstmid.req_before", o_MEM_req, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("rstmid.req", o_MEM_req, 0);
    chk("rstmid.we", o_MEM_we, 0);
    chk("rstmid.addr", o_MEM_addr, 0);
    chk("rstmid.rdy", {o_IC_MemReady, o_DM_data_ready}, 0);
    chk("rstmid.instr", o_IM_Instr, 0);
    chk("rstmid.dmrd", o_DM_ReadData, 0);
    exp_instr = '0; exp_dmrd = '0; dm_known = 1'b1; pref_d = (DP != 0);
    i_DM_Wen = 1'b0;
    step();
    i_rst = 1'b0;
    i_IC_DataReq = 1'b1; i_IM_Addr = 32'h0000_0400;
    serve(1'b0, 1, 32'hCAFE_0001, "post_rst_fetch");

    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(1, 3);
      i_IM_Addr    = {1'b0, $urandom_range(0, 32'h7FFF_FFFF)} & ~32'h3;
      i_DM_Addr    = {1'b1, 31'($urandom)};
      i_DM_Wd      = $urandom;
      i_DM_byte_en = 4'($urandom_range(1, 15));
      if (mode != 2) i_IC_DataReq = 1'b1;
      if (mode != 1) begin
        i_DM_MemRead = 1'($urandom);
        i_DM_Wen     = !i_DM_MemRead || 1'($urandom);
      end
      if (mode == 3) begin
        w = tie_goes_to_d();
        serve(w, $urandom_range(1, 4), $urandom, "rnd_tie_a");
        serve(!w, $urandom_range(1, 4), $urandom, "rnd_tie_b");
      end else begin
        serve(mode == 2, $urandom_range(1, 4), $urandom, "rnd_single");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
